rom_fetch_arbiter: RTL and testbench

Shares the single SDRAM ROM read port between the M68K program ROM and the Z80 sound ROM. It converts each requester's decoded ROM select into an SDRAM request/acknowledge transaction, and returns data with M68K DTACK or Z80 WAIT. Arbitration between the two requesters is round-robin. Each requester has a one-word hit cache. The block sits between the address decoder's `m68k_rom_cs`/`z80_rom_cs` outputs and the SDRAM controller.

---
 rtl/rom_fetch_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_rom_fetch_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_arbiter.sv
// Shares one SDRAM read port between the M68K program ROM and the Z80 sound ROM,
// with a one-word hit cache per requester and round-robin arbitration on misses.
module rom_fetch_arbiter #(
    parameter logic [24:0] M68K_BASE = 25'h0000000,
    parameter logic [24:0] Z80_BASE  = 25'h0040000
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m68k_rom_cs,
    input  logic [23:1] m68k_a,
    output logic [15:0] m68k_rom_data,
    output logic        m68k_rom_dtack,

    input  logic        z80_rom_cs,
    input  logic [15:0] z80_addr,
    output logic [7:0]  z80_rom_data,
    output logic        z80_wait_n,

    output logic        sdr_req,
    output logic [24:0] sdr_addr,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_q
);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t      state;
    logic        gnt_z80;
    logic        last_z80;

    logic        m68k_cs_d;
    logic        m68k_pend;
    logic        m68k_abort;
    logic [22:0] m68k_req_tag;
    logic [22:0] m68k_fetch_tag;
    logic [22:0] m68k_cache_tag;
    logic [15:0] m68k_cache_word;
    logic        m68k_cache_valid;

    logic        z80_cs_d;
    logic        z80_pend;
    logic        z80_abort;
    logic [14:0] z80_req_tag;
    logic        z80_req_bsel;
    logic [14:0] z80_fetch_tag;
    logic [14:0] z80_cache_tag;
    logic [15:0] z80_cache_word;
    logic        z80_cache_valid;
    logic        z80_rdy;

    logic        m68k_new;
    logic        m68k_hit;
    logic        m68k_ack;
    logic        m68k_done;
    logic        z80_new;
    logic        z80_hit;
    logic        z80_ack;
    logic        z80_done;
    logic        grant_z80_next;
    logic [24:0] m68k_fetch_addr;
    logic [24:0] z80_fetch_addr;

    // A fetch only completes the request if no newer miss replaced its tag meanwhile;
    // otherwise the requester stays pending and the newer word is fetched next.
    always_comb begin
        m68k_new        = m68k_rom_cs & ~m68k_cs_d;
        m68k_hit        = m68k_new & m68k_cache_valid & (m68k_a == m68k_cache_tag);
        z80_new         = z80_rom_cs & ~z80_cs_d;
        z80_hit         = z80_new & z80_cache_valid & (z80_addr[15:1] == z80_cache_tag);
        m68k_ack        = (state == S_REQ) & sdr_ack & ~gnt_z80;
        z80_ack         = (state == S_REQ) & sdr_ack & gnt_z80;
        m68k_done       = m68k_ack & (m68k_fetch_tag == m68k_req_tag);
        z80_done        = z80_ack & (z80_fetch_tag == z80_req_tag);
        grant_z80_next  = z80_pend & (~m68k_pend | ~last_z80);
        m68k_fetch_addr = M68K_BASE + {1'b0, m68k_req_tag, 1'b0};
        z80_fetch_addr  = Z80_BASE + {9'b0, z80_req_tag, 1'b0};
    end

    assign z80_wait_n = ~(z80_rom_cs & ~z80_rdy);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            gnt_z80        <= 1'b0;
            last_z80       <= 1'b1;
            sdr_req        <= 1'b0;
            sdr_addr       <= '0;
            m68k_fetch_tag <= '0;
            z80_fetch_tag  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m68k_pend || z80_pend) begin
                        state   <= S_REQ;
                        sdr_req <= 1'b1;
                        gnt_z80 <= grant_z80_next;
                        if (grant_z80_next) begin
                            sdr_addr      <= z80_fetch_addr;
                            z80_fetch_tag <= z80_req_tag;
                        end else begin
                            sdr_addr       <= m68k_fetch_addr;
                            m68k_fetch_tag <= m68k_req_tag;
                        end
                    end
                end
                S_REQ: begin
                    if (sdr_ack) begin
                        state    <= S_IDLE;
                        sdr_req  <= 1'b0;
                        last_z80 <= gnt_z80;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    sdr_req <= 1'b0;
                end
            endcase
        end
    end

    // M68K side: miss capture, cache fill and DTACK.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m68k_cs_d        <= 1'b0;
            m68k_pend        <= 1'b0;
            m68k_abort       <= 1'b0;
            m68k_req_tag     <= '0;
            m68k_cache_tag   <= '0;
            m68k_cache_word  <= '0;
            m68k_cache_valid <= 1'b0;
            m68k_rom_data    <= '0;
            m68k_rom_dtack   <= 1'b0;
        end else begin
            m68k_cs_d <= m68k_rom_cs;
            if (!m68k_rom_cs) begin
                m68k_abort     <= 1'b1;
                m68k_rom_dtack <= 1'b0;
            end
            if (m68k_ack) begin
                m68k_cache_tag   <= m68k_fetch_tag;
                m68k_cache_word  <= sdr_q;
                m68k_cache_valid <= 1'b1;
            end
            if (m68k_done) begin
                m68k_pend <= 1'b0;
                if (m68k_rom_cs && !m68k_abort) begin
                    m68k_rom_data  <= sdr_q;
                    m68k_rom_dtack <= 1'b1;
                end
            end
            if (m68k_hit) begin
                m68k_rom_data  <= m68k_cache_word;
                m68k_rom_dtack <= 1'b1;
            end else if (m68k_new) begin
                m68k_pend    <= 1'b1;
                m68k_abort   <= 1'b0;
                m68k_req_tag <= m68k_a;
            end
        end
    end

    // Z80 side: same scheme, returning the addressed byte of the word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z80_cs_d        <= 1'b0;
            z80_pend        <= 1'b0;
            z80_abort       <= 1'b0;
            z80_req_tag     <= '0;
            z80_req_bsel    <= 1'b0;
            z80_cache_tag   <= '0;
            z80_cache_word  <= '0;
            z80_cache_valid <= 1'b0;
            z80_rom_data    <= '0;
            z80_rdy         <= 1'b0;
        end else begin
            z80_cs_d <= z80_rom_cs;
            if (!z80_rom_cs) begin
                z80_abort <= 1'b1;
                z80_rdy   <= 1'b0;
            end
            if (z80_ack) begin
                z80_cache_tag   <= z80_fetch_tag;
                z80_cache_word  <= sdr_q;
                z80_cache_valid <= 1'b1;
            end
            if (z80_done) begin
                z80_pend <= 1'b0;
                if (z80_rom_cs && !z80_abort) begin
                    z80_rom_data <= z80_req_bsel ? sdr_q[15:8] : sdr_q[7:0];
                    z80_rdy      <= 1'b1;
                end
            end
            if (z80_hit) begin
                z80_rom_data <= z80_addr[0] ? z80_cache_word[15:8] : z80_cache_word[7:0];
                z80_rdy      <= 1'b1;
            end else if (z80_new) begin
                z80_pend     <= 1'b1;
                z80_abort    <= 1'b0;
                z80_req_tag  <= z80_addr[15:1];
                z80_req_bsel <= z80_addr[0];
            end
        end
    end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter: a per-cycle vector table for the basic
// miss/hit flows, then hand-written sequences for arbitration, abort and reset.
module tb_rom_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m68k_rom_cs = 1'b0;
    logic [23:1] m68k_a = '0;
    logic [15:0] m68k_rom_data;
    logic        m68k_rom_dtack;
    logic        z80_rom_cs = 1'b0;
    logic [15:0] z80_addr = '0;
    logic [7:0]  z80_rom_data;
    logic        z80_wait_n;
    logic        sdr_req;
    logic [24:0] sdr_addr;
    logic        sdr_ack = 1'b0;
    logic [15:0] sdr_q = '0;

    int vec_count  = 0;
    int fail_count = 0;

    typedef struct packed {
        logic        m_cs;
        logic [22:0] m_a;
        logic        z_cs;
        logic [15:0] z_a;
        logic        ack;
        logic [15:0] q;
        logic        e_req;
        logic [24:0] e_addr;
        logic        e_dtack;
        logic [15:0] e_mdata;
        logic        e_wn_pre;
        logic        e_wn;
        logic [7:0]  e_zdata;
    } vec_t;

    vec_t vecs [17];

    rom_fetch_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m68k_rom_cs    (m68k_rom_cs),
        .m68k_a         (m68k_a),
        .m68k_rom_data  (m68k_rom_data),
        .m68k_rom_dtack (m68k_rom_dtack),
        .z80_rom_cs     (z80_rom_cs),
        .z80_addr       (z80_addr),
        .z80_rom_data   (z80_rom_data),
        .z80_wait_n     (z80_wait_n),
        .sdr_req        (sdr_req),
        .sdr_addr       (sdr_addr),
        .sdr_ack        (sdr_ack),
        .sdr_q          (sdr_q)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic m_cs, input logic [22:0] m_a, input logic z_cs, input logic [15:0] z_a,
        input logic ack, input logic [15:0] q, input logic e_req, input logic [24:0] e_addr,
        input logic e_dtack, input logic [15:0] e_mdata, input logic e_wn_pre,
        input logic e_wn, input logic [7:0] e_zdata);
        vec_t v;
        v = '{m_cs, m_a, z_cs, z_a, ack, q, e_req, e_addr, e_dtack, e_mdata, e_wn_pre, e_wn, e_zdata};
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ack_pulse(input logic [15:0] q);
        sdr_ack = 1'b1;
        sdr_q   = q;
        tick();
        sdr_ack = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        m68k_rom_cs = v.m_cs;
        m68k_a      = v.m_a;
        z80_rom_cs  = v.z_cs;
        z80_addr    = v.z_a;
        sdr_ack     = v.ack;
        sdr_q       = v.q;
        #1;
        tag = $sformatf("vec%0d", idx);
        check_output({tag, " wait_n_pre"}, 32'(z80_wait_n), 32'(v.e_wn_pre));
        tick();
        check_output({tag, " sdr_req"},   32'(sdr_req),        32'(v.e_req));
        check_output({tag, " sdr_addr"},  32'(sdr_addr),       32'(v.e_addr));
        check_output({tag, " dtack"},     32'(m68k_rom_dtack), 32'(v.e_dtack));
        check_output({tag, " m68k_data"}, 32'(m68k_rom_data),  32'(v.e_mdata));
        check_output({tag, " wait_n"},    32'(z80_wait_n),     32'(v.e_wn));
        check_output({tag, " z80_data"},  32'(z80_rom_data),   32'(v.e_zdata));
    endtask

    initial begin
        // M68K miss at word 0x10, ack three cycles after the request, DTACK release, then a hit.
        vecs[0]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h0,     0, 16'h0,    1, 1, 8'h00);
        vecs[1]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    1, 25'h20,    0, 16'h0,    1, 1, 8'h00);
        vecs[2]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    1, 25'h20,    0, 16'h0,    1, 1, 8'h00);
        vecs[3]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    1, 25'h20,    0, 16'h0,    1, 1, 8'h00);
        vecs[4]  = mk(1, 23'h10, 0, 16'h0,    1, 16'h4E71, 0, 25'h20,    1, 16'h4E71, 1, 1, 8'h00);
        vecs[5]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    1, 16'h4E71, 1, 1, 8'h00);
        vecs[6]  = mk(0, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    0, 16'h4E71, 1, 1, 8'h00);
        vecs[7]  = mk(0, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    0, 16'h4E71, 1, 1, 8'h00);
        vecs[8]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    1, 16'h4E71, 1, 1, 8'h00);
        vecs[9]  = mk(1, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    1, 16'h4E71, 1, 1, 8'h00);
        vecs[10] = mk(0, 23'h10, 0, 16'h0,    0, 16'h0,    0, 25'h20,    0, 16'h4E71, 1, 1, 8'h00);
        // Z80 miss on odd byte 0x1235, then a hit on the even byte of the same word.
        vecs[11] = mk(0, 23'h10, 1, 16'h1235, 0, 16'h0,    0, 25'h20,    0, 16'h4E71, 0, 0, 8'h00);
        vecs[12] = mk(0, 23'h10, 1, 16'h1235, 0, 16'h0,    1, 25'h41234, 0, 16'h4E71, 0, 0, 8'h00);
        vecs[13] = mk(0, 23'h10, 1, 16'h1235, 1, 16'hABCD, 0, 25'h41234, 0, 16'h4E71, 0, 1, 8'hAB);
        vecs[14] = mk(0, 23'h10, 0, 16'h1235, 0, 16'h0,    0, 25'h41234, 0, 16'h4E71, 1, 1, 8'hAB);
        vecs[15] = mk(0, 23'h10, 1, 16'h1234, 0, 16'h0,    0, 25'h41234, 0, 16'h4E71, 0, 1, 8'hCD);
        vecs[16] = mk(0, 23'h10, 0, 16'h1234, 0, 16'h0,    0, 25'h41234, 0, 16'h4E71, 1, 1, 8'hCD);

        tick();
        tick();
        check_output("rst sdr_req",   32'(sdr_req),        32'h0);
        check_output("rst sdr_addr",  32'(sdr_addr),       32'h0);
        check_output("rst dtack",     32'(m68k_rom_dtack), 32'h0);
        check_output("rst m68k_data", 32'(m68k_rom_data),  32'h0);
        check_output("rst z80_data",  32'(z80_rom_data),   32'h0);
        check_output("rst wait_n",    32'(z80_wait_n),     32'h1);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // Tie right after reset: M68K first, Z80 granted one cycle after the M68K ack.
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
        m68k_rom_cs = 1'b1; m68k_a = 23'h100;
        z80_rom_cs  = 1'b1; z80_addr = 16'h0200;
        tick();
        check_output("tie1 req E0", 32'(sdr_req), 32'h0);
        tick();
        check_output("tie1 req E1",  32'(sdr_req),  32'h1);
        check_output("tie1 addr M",  32'(sdr_addr), 32'h200);
        tick();
        ack_pulse(16'h1111);
        check_output("tie1 req ack",  32'(sdr_req),        32'h0);
        check_output("tie1 dtack",    32'(m68k_rom_dtack), 32'h1);
        check_output("tie1 m_data",   32'(m68k_rom_data),  32'h1111);
        check_output("tie1 wait_n",   32'(z80_wait_n),     32'h0);
        tick();
        check_output("tie1 req Z",    32'(sdr_req),  32'h1);
        check_output("tie1 addr Z",   32'(sdr_addr), 32'h40200);
        ack_pulse(16'h2233);
        check_output("tie1 z wait_n", 32'(z80_wait_n),   32'h1);
        check_output("tie1 z_data",   32'(z80_rom_data), 32'h33);
        m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
        tick();
        check_output("tie1 dtack rel", 32'(m68k_rom_dtack), 32'h0);

        // Serve M68K alone so the next tie favours the Z80.
        m68k_rom_cs = 1'b1; m68k_a = 23'h200;
        tick();
        tick();
        check_output("m2 addr", 32'(sdr_addr), 32'h400);
        ack_pulse(16'h1357);
        check_output("m2 m_data", 32'(m68k_rom_data), 32'h1357);
        m68k_rom_cs = 1'b0;
        tick();

        m68k_rom_cs = 1'b1; m68k_a = 23'h300;
        z80_rom_cs  = 1'b1; z80_addr = 16'h0400;
        tick();
        tick();
        check_output("tie2 req Z",  32'(sdr_req),  32'h1);
        check_output("tie2 addr Z", 32'(sdr_addr), 32'h40400);
        ack_pulse(16'h7788);
        check_output("tie2 z_data", 32'(z80_rom_data),   32'h88);
        check_output("tie2 dtack",  32'(m68k_rom_dtack), 32'h0);
        tick();
        check_output("tie2 addr M", 32'(sdr_addr), 32'h600);
        ack_pulse(16'h2468);
        check_output("tie2 m_data", 32'(m68k_rom_data), 32'h2468);
        m68k_rom_cs = 1'b0; z80_rom_cs = 1'b0;
        tick();

        // Z80 cycle aborted during the SDRAM access: fill without ready, then hit.
        z80_rom_cs = 1'b1; z80_addr = 16'h0500;
        tick();
        tick();
        check_output("abort addr", 32'(sdr_addr), 32'h40500);
        z80_rom_cs = 1'b0;
        #1;
        check_output("abort wait_n low cs", 32'(z80_wait_n), 32'h1);
        tick();
        check_output("abort req held", 32'(sdr_req),    32'h1);
        check_output("abort wait_n",   32'(z80_wait_n), 32'h1);
        ack_pulse(16'h5AC3);
        check_output("abort req done", 32'(sdr_req),      32'h0);
        check_output("abort z_data",   32'(z80_rom_data), 32'h88);
        tick();
        z80_rom_cs = 1'b1; z80_addr = 16'h0501;
        #1;
        check_output("abort hit wait_pre", 32'(z80_wait_n), 32'h0);
        tick();
        check_output("abort hit wait_n", 32'(z80_wait_n),   32'h1);
        check_output("abort hit z_data", 32'(z80_rom_data), 32'h5A);
        check_output("abort hit req",    32'(sdr_req),      32'h0);
        tick();
        check_output("abort hit req2",   32'(sdr_req),      32'h0);
        z80_rom_cs = 1'b0;
        tick();

        // Reset while a request is outstanding; the late ack must not fill anything.
        m68k_rom_cs = 1'b1; m68k_a = 23'h700;
        tick();
        tick();
        check_output("rreq req", 32'(sdr_req), 32'h1);
        reset_n = 1'b0;
        #1;
        check_output("rreq async req", 32'(sdr_req), 32'h0);
        m68k_rom_cs = 1'b0;
        tick();
        reset_n = 1'b1;
        ack_pulse(16'hFFFF);
        check_output("rreq late req",   32'(sdr_req),        32'h0);
        check_output("rreq late dtack", 32'(m68k_rom_dtack), 32'h0);
        check_output("rreq late data",  32'(m68k_rom_data),  32'h0);
        m68k_rom_cs = 1'b1; m68k_a = 23'h700;
        tick();
        check_output("rreq miss dtack", 32'(m68k_rom_dtack), 32'h0);
        tick();
        check_output("rreq miss req",   32'(sdr_req),  32'h1);
        check_output("rreq miss addr",  32'(sdr_addr), 32'hE00);
        ack_pulse(16'h0F0F);
        check_output("rreq data",       32'(m68k_rom_data), 32'h0F0F);
        m68k_rom_cs = 1'b0;
        tick();
        m68k_rom_cs = 1'b1; m68k_a = 23'h300;
        tick();
        check_output("inval dtack", 32'(m68k_rom_dtack), 32'h0);
        tick();
        check_output("inval req",   32'(sdr_req),  32'h1);
        check_output("inval addr",  32'(sdr_addr), 32'h600);
        ack_pulse(16'h2468);
        check_output("inval dtack2", 32'(m68k_rom_dtack), 32'h1);
        m68k_rom_cs = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
